// File: rtl/activity_pkg.sv
// Shared types and helpers for the activity monitor: edge-mode encoding and
// per-channel field extraction from packed configuration buses.
package activity_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    // Widest edge_mode bus the helper can slice (two bits per channel).
    localparam int unsigned MODE_BUS_BITS = 256;

    function automatic edge_mode_t channel_mode(input logic [MODE_BUS_BITS-1:0] modes,
                                                input int unsigned ch);
        return edge_mode_t'(modes[2*ch +: 2]);
    endfunction

endpackage

// File: rtl/activity_channel.sv
// One monitored channel: synchroniser, mode-qualified edge detect, event
// counter with sticky overflow, and a retriggerable LED stretch timer.
module activity_channel
    import activity_pkg::*;
#(
    parameter int COUNT_BITS  = 16,
    parameter int HOLD_BITS   = 24,
    parameter int SYNC_STAGES = 2,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sig,
    input  edge_mode_t            edge_mode,
    input  logic [HOLD_BITS-1:0]  hold_cycles,
    input  logic                  clr,
    output logic                  evt_o,
    output logic                  act_o,
    output logic [COUNT_BITS-1:0] count_o,
    output logic                  ovf_o
);

    localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_s;
    logic                   sig_d;
    logic                   rise;
    logic                   fall;
    logic                   evt;
    logic                   evt_q;
    logic [COUNT_BITS-1:0]  count_q;
    logic                   ovf_q;
    logic [HOLD_BITS-1:0]   timer_q;

    // Reset discards in-flight samples so a pre-reset edge can never surface.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
            sig_d  <= sig_s;
        end
    end

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d;
    assign fall  = ~sig_s & sig_d;

    always_comb begin
        evt = 1'b0;
        unique case (edge_mode)
            EDGE_OFF:  evt = 1'b0;
            EDGE_RISE: evt = rise;
            EDGE_FALL: evt = fall;
            EDGE_BOTH: evt = rise | fall;
            default:   evt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= evt;
        end
    end

    // Clear wins over a coincident event; the event still pulses evt_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (evt) begin
            if (count_q == COUNT_MAX) begin
                ovf_q <= 1'b1;
                if (!SATURATE) begin
                    count_q <= '0;
                end
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else if (evt) begin
            timer_q <= hold_cycles;
        end else if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
        end
    end

    assign evt_o   = evt_q;
    assign act_o   = (timer_q != '0);
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/activity_monitor.sv
// Multi-channel edge-event monitor; replicates activity_channel and maps the
// packed per-channel buses onto each instance.
module activity_monitor
    import activity_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int COUNT_BITS  = 16,
    parameter int HOLD_BITS   = 24,
    parameter int SYNC_STAGES = 2,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            sig,
    input  logic [2*NUM_CH-1:0]          edge_mode,
    input  logic [HOLD_BITS-1:0]         hold_cycles,
    input  logic [NUM_CH-1:0]            clr,
    output logic [NUM_CH-1:0]            evt_o,
    output logic [NUM_CH-1:0]            act_o,
    output logic [NUM_CH*COUNT_BITS-1:0] count_o,
    output logic [NUM_CH-1:0]            ovf_o
);

    logic [MODE_BUS_BITS-1:0] mode_bus;

    assign mode_bus = MODE_BUS_BITS'(edge_mode);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        activity_channel #(
            .COUNT_BITS  (COUNT_BITS),
            .HOLD_BITS   (HOLD_BITS),
            .SYNC_STAGES (SYNC_STAGES),
            .SATURATE    (SATURATE)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .sig         (sig[ch]),
            .edge_mode   (channel_mode(mode_bus, ch)),
            .hold_cycles (hold_cycles),
            .clr         (clr[ch]),
            .evt_o       (evt_o[ch]),
            .act_o       (act_o[ch]),
            .count_o     (count_o[ch*COUNT_BITS +: COUNT_BITS]),
            .ovf_o       (ovf_o[ch])
        );
    end

endmodule

// File: tb/tb_activity_monitor.sv
// Randomised directed bench for activity_monitor: a saturating and a wrapping
// instance share stimulus and are compared each cycle to an event-history model.
module tb_activity_monitor;

    localparam int NUM_CH      = 4;
    localparam int COUNT_BITS  = 4;
    localparam int HOLD_BITS   = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CMAX        = (1 << COUNT_BITS) - 1;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [NUM_CH-1:0]            sig = '0;
    logic [2*NUM_CH-1:0]          edge_mode = '0;
    logic [HOLD_BITS-1:0]         hold_cycles = '0;
    logic [NUM_CH-1:0]            clr = '0;

    logic [NUM_CH-1:0]            evt_sat, act_sat, ovf_sat;
    logic [NUM_CH*COUNT_BITS-1:0] count_sat;
    logic [NUM_CH-1:0]            evt_wrap, act_wrap, ovf_wrap;
    logic [NUM_CH*COUNT_BITS-1:0] count_wrap;

    activity_monitor #(
        .NUM_CH(NUM_CH), .COUNT_BITS(COUNT_BITS), .HOLD_BITS(HOLD_BITS),
        .SYNC_STAGES(SYNC_STAGES), .SATURATE(1'b1)
    ) dut_sat (
        .clk(clk), .rst(rst), .sig(sig), .edge_mode(edge_mode),
        .hold_cycles(hold_cycles), .clr(clr), .evt_o(evt_sat),
        .act_o(act_sat), .count_o(count_sat), .ovf_o(ovf_sat)
    );

    activity_monitor #(
        .NUM_CH(NUM_CH), .COUNT_BITS(COUNT_BITS), .HOLD_BITS(HOLD_BITS),
        .SYNC_STAGES(SYNC_STAGES), .SATURATE(1'b0)
    ) dut_wrap (
        .clk(clk), .rst(rst), .sig(sig), .edge_mode(edge_mode),
        .hold_cycles(hold_cycles), .clr(clr), .evt_o(evt_wrap),
        .act_o(act_wrap), .count_o(count_wrap), .ovf_o(ovf_wrap)
    );

    initial forever #5 clk = ~clk;

    // Model: sampled input history, events since last clear, last event time.
    logic [NUM_CH-1:0] hist[$];
    logic [NUM_CH-1:0] exp_evt;
    int                total[NUM_CH];
    int                last_evt[NUM_CH];
    int                hold_loaded[NUM_CH];
    int                edge_no = 0;
    int                compared = 0;
    int                mismatched = 0;

    task automatic modelEdge();
        logic [NUM_CH-1:0] now_s;
        logic [NUM_CH-1:0] prev_s;
        logic [1:0]        mode;
        logic              ev;
        edge_no++;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < SYNC_STAGES + 2; i++) hist.push_front('0);
            exp_evt = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                total[ch]       = 0;
                hold_loaded[ch] = 0;
                last_evt[ch]    = edge_no;
            end
        end else begin
            hist.push_front(sig);
            while (hist.size() > SYNC_STAGES + 2) void'(hist.pop_back());
            now_s  = hist[SYNC_STAGES];
            prev_s = hist[SYNC_STAGES+1];
            for (int ch = 0; ch < NUM_CH; ch++) begin
                mode = edge_mode[2*ch +: 2];
                ev   = (mode == 2'b01 && now_s[ch] && !prev_s[ch]) ||
                       (mode == 2'b10 && !now_s[ch] && prev_s[ch]) ||
                       (mode == 2'b11 && now_s[ch] != prev_s[ch]);
                exp_evt[ch] = ev;
                if (clr[ch]) total[ch] = 0;
                else if (ev) total[ch]++;
                if (ev) begin
                    last_evt[ch]    = edge_no;
                    hold_loaded[ch] = int'(hold_cycles);
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s at edge %0d: observed=%h expected=%h",
                   tag, edge_no, observed, expected);
        end
    endtask

    task automatic checkOutput();
        logic [NUM_CH-1:0]            e_act, e_ovf;
        logic [NUM_CH*COUNT_BITS-1:0] e_cnt_sat, e_cnt_wrap;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            e_act[ch] = (edge_no - last_evt[ch]) < hold_loaded[ch];
            e_ovf[ch] = total[ch] > CMAX;
            e_cnt_sat[ch*COUNT_BITS +: COUNT_BITS] =
                COUNT_BITS'((total[ch] > CMAX) ? CMAX : total[ch]);
            e_cnt_wrap[ch*COUNT_BITS +: COUNT_BITS] =
                COUNT_BITS'(total[ch] % (CMAX + 1));
        end
        check("evt_sat",    32'(evt_sat),    32'(exp_evt));
        check("act_sat",    32'(act_sat),    32'(e_act));
        check("count_sat",  32'(count_sat),  32'(e_cnt_sat));
        check("ovf_sat",    32'(ovf_sat),    32'(e_ovf));
        check("evt_wrap",   32'(evt_wrap),   32'(exp_evt));
        check("act_wrap",   32'(act_wrap),   32'(e_act));
        check("count_wrap", 32'(count_wrap), 32'(e_cnt_wrap));
        check("ovf_wrap",   32'(ovf_wrap),   32'(e_ovf));
    endtask

    // Present inputs just after an edge, then model and check the next edge.
    task automatic applyStimulus(input logic [NUM_CH-1:0] s, input logic [2*NUM_CH-1:0] m,
                                 input int h, input logic [NUM_CH-1:0] c, input logic r);
        sig         = s;
        edge_mode   = m;
        hold_cycles = HOLD_BITS'(h);
        clr         = c;
        rst         = r;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic randomPhase(input int cycles, input logic [2*NUM_CH-1:0] m,
                               input bit rand_mode);
        logic [NUM_CH-1:0]   s;
        logic [2*NUM_CH-1:0] mm;
        logic [NUM_CH-1:0]   c;
        s = sig;
        for (int i = 0; i < cycles; i++) begin
            s  = s ^ NUM_CH'($urandom_range(0, 15) & $urandom_range(0, 15));
            mm = rand_mode ? (2*NUM_CH)'($urandom) : m;
            c  = ($urandom_range(0, 11) == 0) ? NUM_CH'($urandom) : '0;
            applyStimulus(s, mm, $urandom_range(0, 12), c, 1'b0);
        end
    endtask

    initial begin
        $display("[TB] activity_monitor bench start");
        repeat (3) applyStimulus('0, '0, 0, '0, 1'b1);

        // Single rising edge on channel 0, hold 5.
        repeat (4) applyStimulus('0, 8'h55, 5, '0, 1'b0);
        repeat (12) applyStimulus(4'b0001, 8'h55, 5, '0, 1'b0);

        // Ch0 toggled every 4 cycles in both/falling/off modes.
        for (int m = 0; m < 3; m++) begin
            for (int t = 0; t < 6; t++) begin
                repeat (4) applyStimulus({3'b000, ~sig[0]} & 4'b0001,
                                         (m == 0) ? 8'hFF : (m == 1) ? 8'hAA : 8'h00,
                                         3, '0, 1'b0);
            end
            repeat (6) applyStimulus(sig, edge_mode, 3, 4'hF, 1'b0);
        end

        // Retrigger: events six cycles apart with hold 10, then hold 0.
        repeat (2) begin
            applyStimulus(4'h0, 8'hFF, 10, '0, 1'b0);
            repeat (5) applyStimulus(4'h0, 8'hFF, 10, '0, 1'b0);
            applyStimulus(4'hF, 8'hFF, 10, '0, 1'b0);
            repeat (14) applyStimulus(4'hF, 8'hFF, 10, '0, 1'b0);
        end
        repeat (10) applyStimulus(~sig, 8'hFF, 0, '0, 1'b0);

        // Overflow on all channels simultaneously, then clear and recount.
        repeat (40) applyStimulus(~sig, 8'hFF, 4, '0, 1'b0);
        repeat (2) applyStimulus(sig, 8'hFF, 4, 4'hF, 1'b0);
        repeat (20) applyStimulus(~sig, 8'hFF, 4, '0, 1'b0);
        repeat (4) applyStimulus(~sig, 8'hFF, 4, 4'b0101, 1'b0);

        randomPhase(60, 8'hFF, 1'b0);
        randomPhase(60, 8'h55, 1'b0);
        randomPhase(60, 8'h00, 1'b0);

        // Reset mid-stretch with edges still in the synchroniser.
        repeat (6) applyStimulus(~sig, 8'hFF, 12, '0, 1'b0);
        applyStimulus(~sig, 8'hFF, 12, '0, 1'b1);
        repeat (8) applyStimulus(sig, 8'hFF, 12, '0, 1'b0);

        // Inputs high across reset release: one rising event per channel.
        repeat (3) applyStimulus(4'hF, 8'h55, 6, '0, 1'b1);
        repeat (12) applyStimulus(4'hF, 8'h55, 6, '0, 1'b0);

        randomPhase(300, '0, 1'b1);
        repeat (2) applyStimulus(sig, edge_mode, 2, '0, 1'b1);
        randomPhase(100, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/activity_monitor.md
Name: activity_monitor

Overview:
- Multi-channel edge-event monitor for LEDs and debug status registers.
- Each channel synchronises an asynchronous input and detects edges in a per-channel selectable mode.
- Each channel keeps a saturating or wrapping event counter with sticky overflow, and drives a retriggerable pulse-stretched activity output sized for human-visible LEDs.
- Instantiated at top level beside the frame/UART/I2C paths it observes; counters are read by the CSR block.

Parameters:
- NUM_CH, 4: number of independent channels, ≥1.
- COUNT_BITS, 16: event counter width per channel, ≥2.
- HOLD_BITS, 24: activity stretch timer width.
- SYNC_STAGES, 2: synchroniser depth, ≥2.
- SATURATE, 1: 1 = counters saturate at all-ones; 0 = counters wrap.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sig  in  NUM_CH  asynchronous monitored inputs; bit i belongs to channel i.
- edge_mode  in  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- hold_cycles  in  HOLD_BITS  stretch length in clk cycles, shared by all channels; sampled when an event occurs.
- clr  in  NUM_CH  per-channel counter and overflow clear, level-sensitive.
- evt_o  out  NUM_CH  one-cycle registered event pulse.
- act_o  out  NUM_CH  stretched activity indication.
- count_o  out  NUM_CH*COUNT_BITS  event counters; channel i occupies [i*COUNT_BITS +: COUNT_BITS].
- ovf_o  out  NUM_CH  sticky overflow flag per channel.

Behaviour:
- Reset: all synchroniser flops and delay flops = 0; evt_o = 0, act_o = 0, count_o = 0, ovf_o = 0, hold timers = 0.
- Synchroniser: each channel passes sig through SYNC_STAGES flops to give sig_s; a further flop gives sig_d.
- Edge decode:
  - rise = sig_s & ~sig_d; fall = ~sig_s & sig_d.
  - The event is qualified by edge_mode: off never fires; rising uses rise; falling uses fall; both uses rise|fall.
- Latency: if sig is first sampled at its new level at edge k, then evt_o, the counter update and the hold-timer load all occur at edge k+SYNC_STAGES. evt_o is high for exactly one cycle.
- Post-reset edge: an input held high through reset produces a rising event SYNC_STAGES+1 edges after reset deasserts. This is intended.
- Pulse rule: an input pulse shorter than one clk period may be missed. Two edges closer than one cycle after synchronisation are not distinguishable; each cycle yields at most one event per channel.
- Counter:
  - On an event, count += 1.
  - At all-ones with SATURATE=1, count holds and ovf is set.
  - With SATURATE=0, count wraps to 0 and ovf is set.
  - ovf stays set until clr.
- clr priority: clr has priority over an event in the same cycle. count becomes 0 and ovf becomes 0; the event is not counted but evt_o still pulses. While clr is held, count stays 0.
- Hold timer:
  - On an event, the timer loads hold_cycles; otherwise it decrements when nonzero.
  - act_o = (timer != 0), taken from the register.
  - act_o therefore rises with evt_o and stays high for exactly hold_cycles cycles after the last event.
  - An event while the timer is active reloads it (retrigger).
  - hold_cycles = 0: act_o never asserts.
  - hold_cycles changing mid-stretch affects only the next load.
- Mode changes:
  - Switching edge_mode to off suppresses new events only; the current stretch decays normally and counters hold.
  - A mode change takes effect on the cycle it is presented; no pipeline replay.
- Reset mid-operation: all state returns to reset values on the next edge, and any in-flight synchroniser data is discarded.
- Channels are fully independent. Simultaneous events on all channels are each handled in the same cycle.

Decomposition:
- Package activity_pkg:
  - edge_mode_t enum: EDGE_OFF = 2'b00, EDGE_RISE = 2'b01, EDGE_FALL = 2'b10, EDGE_BOTH = 2'b11.
  - Helper function that slices channel i from a packed vector.
- Sub-module activity_channel, one per channel via generate:
  - Contains synchroniser, edge decode, counter and hold timer.
  - Has the same parameters except NUM_CH.
- Top level only slices and concatenates the packed buses.

Test Plan:
- Rising-edge count: SYNC_STAGES=2, mode 01, hold_cycles=5; sig0 0→1 sampled at edge 10 → evt_o[0] high after edge 12 for 1 cycle; count0=1; act_o[0] high for exactly 5 cycles.
- Mode 11 with sig toggled every 4 cycles ×6 → 6 evt pulses, count=6. Repeat with mode 10 → count=3. Repeat with mode 00 → count=0, act_o never asserts.
- Retrigger: hold_cycles=10; events at cycles 0 and 6 → act_o continuous for 16 cycles. hold_cycles=0 → act_o stays 0 while count still increments.
- Overflow: COUNT_BITS=4; 17 events with SATURATE=1 → count=15, ovf=1. Same with SATURATE=0 → count=1, ovf=1. Then clr → count=0, ovf=0.
- clr coincident with an event → count=0 and evt_o pulses. Events on all 4 channels in the same cycle → each count=1.
- rst asserted mid-stretch and mid-sync → every output 0 on the next edge. sig held high across reset release → exactly one rising event per channel.
